// File: rtl/fp_mult_issue_if.sv
// -----------------------------------------------------------------------------
// fp_mult_issue_if
// Bundles the operand FIFO handshake and the multiplier-side signals of
// fp_mult_issue.
//   master : the operand source. Drives in_valid/in_a/in_b and observes the rest.
//   slave  : the issue block. Accepts operands and drives the multiplier
//            controls, the flags, busy and level.
// Signals:
//   in_valid, in_ready  operand-pair handshake
//   in_a, in_b          IEEE-754 single-precision operands
//   mul_a, mul_b        operands held for the multiplier
//   mul_load, mul_done  multiplier load pulse and completion strobe
//   out_zero            flag for the pair in flight
//   out_special         flag for the pair in flight
//   busy                issue FSM is not idle
//   level               FIFO occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
interface fp_mult_issue_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_load;
    logic             mul_done;
    logic             out_zero;
    logic             out_special;
    logic             busy;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, mul_a, mul_b, mul_load, mul_done,
        input  out_zero, out_special, busy, level
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, mul_a, mul_b, mul_load, mul_done,
        output out_zero, out_special, busy, level
    );
endinterface

// File: rtl/fp_mult_issue.sv
// -----------------------------------------------------------------------------
// fp_mult_issue
// Operand FIFO plus issue sequencer for an iterative (Booth) FP multiplier.
// Operand pairs are queued in a DEPTH-entry FIFO. The head is popped into
// mul_a/mul_b. The sequencer then pulses mul_load, waits ITER cycles, and
// strobes mul_done. Zero and special (exponent all-ones) operands are flagged
// when the pair is popped.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset. It aborts the pair in flight and
//        discards the FIFO contents.
//   bus  fp_mult_issue_if.slave (handshake, multiplier controls, flags, level)
//
// Parameters:
//   DEPTH  FIFO entries (power of 2, 2..16)
//   ITER   Booth iteration cycles per product
//
// Optional feature (macro FP_ISSUE_BYPASS_EN):
//   When this macro is defined, a popped pair with a zero or special operand
//   skips LOAD/RUN. It goes straight to DONE, so mul_done is high in the cycle
//   after the pop. When the macro is undefined, every pair takes the full path.
// -----------------------------------------------------------------------------
module fp_mult_issue #(
    parameter int DEPTH = 4,
    parameter int ITER  = 24
) (
    input  logic          clk,
    input  logic          rst,
    fp_mult_issue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [31:0]      fifo_a [DEPTH];
    logic [31:0]      fifo_b [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      mul_a_r, mul_b_r;
    logic             zero_r, special_r;

    logic             full, push, pop, bypass;
    logic [31:0]      head_a, head_b;
    logic             head_zero, head_special;

    assign full   = (level == LVL_FULL);
    assign push   = bus.in_valid && bus.in_ready;
    assign head_a = fifo_a[rd_ptr];
    assign head_b = fifo_b[rd_ptr];

    // The sign bit is ignored, so that -0 counts as zero.
    assign head_zero    = (head_a[30:0] == 31'd0) || (head_b[30:0] == 31'd0);
    assign head_special = (head_a[30:23] == 8'hFF) || (head_b[30:23] == 8'hFF);

`ifdef FP_ISSUE_BYPASS_EN
    assign bypass = head_zero || head_special;
`else
    assign bypass = 1'b0;
`endif

    // FIFO storage. It is not reset, because level and the pointers mark what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= bus.in_a;
            fifo_b[wr_ptr] <= bus.in_b;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Operands and flags are captured at pop. They stay held until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_r   <= '0;
            mul_b_r   <= '0;
            zero_r    <= 1'b0;
            special_r <= 1'b0;
        end else if (pop) begin
            mul_a_r   <= head_a;
            mul_b_r   <= head_b;
            zero_r    <= head_zero;
            special_r <= head_special;
        end
    end

    // Iteration counter: cleared in LOAD, counts 0..ITER-1 in RUN.
    always_ff @(posedge clk) begin
        if (rst)                cnt <= '0;
        else if (state == LOAD) cnt <= '0;
        else if (state == RUN)  cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Pops happen only from IDLE or DONE. level is registered, so a pair
    // pushed into an empty FIFO is popped on the following cycle.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (level != '0 && !rst) begin
                    pop      = 1'b1;
                    state_nx = bypass ? DONE : LOAD;
                end
            end
            LOAD: state_nx = RUN;
            RUN: begin
                if (cnt == CNT_LAST) state_nx = DONE;
            end
            DONE: begin
                if (level != '0 && !rst) begin
                    pop      = 1'b1;
                    state_nx = bypass ? DONE : LOAD;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control outputs are gated by rst, so they read inactive for the whole
    // reset cycle, not only after the reset edge.
    assign bus.in_ready    = !full && !rst;
    assign bus.mul_load    = (state == LOAD) && !rst;
    assign bus.mul_done    = (state == DONE) && !rst;
    assign bus.busy        = (state != IDLE) && !rst;
    assign bus.level       = level;
    assign bus.mul_a       = mul_a_r;
    assign bus.mul_b       = mul_b_r;
    assign bus.out_zero    = zero_r;
    assign bus.out_special = special_r;
endmodule
